// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage owning the PC, hiding the ROM's one-cycle read latency,
// with decode stall, branch redirect and halt at the end of the program.
module fetch_unit #(
    parameter int unsigned         PC_W     = 32,
    parameter int unsigned         ADDR_W   = 7,
    parameter logic [PC_W-1:0]     RESET_PC = '0,
    parameter logic [PC_W-1:0]     END_PC   = PC_W'(140),
    parameter int unsigned         CNT_W    = 16
) (
    input  logic              clock,
    input  logic              Reset,
    input  logic              if_stall,
    input  logic              br_taken,
    input  logic [PC_W-1:0]   br_target,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_dout,
    output logic [PC_W-1:0]   if_pc,
    output logic [31:0]       if_instr,
    output logic              if_valid,
    output logic              halted,
    output logic [CNT_W-1:0]  fetch_count
);
    typedef enum logic [1:0] {PRIME, RUN, HALT} state_e;
    state_e           state_q, state_d;
    logic [PC_W-1:0]  pc_q, pc_d, req_pc_q, req_pc_d, tgt, issue;
    logic             req_valid_q, req_valid_d;
    logic [CNT_W-1:0] fetch_count_q, fetch_count_d;
    logic             in_halt, br_ok, hit, hold, advance, accept;
    // Pick the address to issue this cycle and compute all next-state values.
    // A stalled or halted fetch re-issues the in-flight word so the ROM output stays stable.
    always_comb begin
        tgt           = br_target & ~PC_W'(3);
        in_halt       = state_q == HALT;
        br_ok         = br_taken && (!in_halt || tgt < END_PC);
        hit           = state_q == RUN && !br_taken && !if_stall && pc_q == END_PC;
        hold          = !br_ok && (if_stall || hit || in_halt);
        issue         = br_ok ? tgt : hold ? req_pc_q : pc_q;
        advance       = !hold;
        accept        = req_valid_q && !if_stall && !br_taken;
        pc_d          = advance ? issue + PC_W'(4) : pc_q;
        req_pc_d      = advance ? issue : req_pc_q;
        req_valid_d   = advance ? 1'b1 : (hit || in_halt) ? 1'b0 : req_valid_q;
        state_d       = br_ok ? RUN : hit ? HALT : (state_q == PRIME && !if_stall) ? RUN : state_q;
        fetch_count_d = (accept && fetch_count_q != '1) ? fetch_count_q + CNT_W'(1) : fetch_count_q;
    end
    // Fetch state registers; reset discards any word in flight.
    always_ff @(posedge clock or negedge Reset) begin
        if (!Reset) begin
            state_q       <= PRIME;
            pc_q          <= RESET_PC;
            req_pc_q      <= RESET_PC;
            req_valid_q   <= 1'b0;
            fetch_count_q <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            req_pc_q      <= req_pc_d;
            req_valid_q   <= req_valid_d;
            fetch_count_q <= fetch_count_d;
        end
    end
    assign imem_addr   = issue[ADDR_W+1:2];
    assign if_pc       = req_pc_q;
    assign if_instr    = imem_dout;
    assign if_valid    = req_valid_q;
    assign halted      = state_q == HALT;
    assign fetch_count = fetch_count_q;
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed table-driven bench for fetch_unit with a registered ROM model.
module tb_fetch_unit;
    logic        clock, Reset, if_stall, br_taken;
    logic [31:0] br_target, imem_dout, if_pc, if_instr;
    logic [6:0]  imem_addr;
    logic        if_valid, halted;
    logic [15:0] fetch_count;
    int          n_chk = 0, n_fail = 0;

    typedef struct {
        logic        stall;
        logic        br;
        logic [31:0] tgt;
        logic [6:0]  addr;
        logic        valid;
        logic [31:0] pc;
        logic        halt;
        logic [15:0] cnt;
    } row_t;

    row_t t1[9];
    row_t t2[10];

    fetch_unit dut (
        .clock(clock), .Reset(Reset), .if_stall(if_stall), .br_taken(br_taken),
        .br_target(br_target), .imem_addr(imem_addr), .imem_dout(imem_dout),
        .if_pc(if_pc), .if_instr(if_instr), .if_valid(if_valid), .halted(halted),
        .fetch_count(fetch_count)
    );

    function automatic logic [31:0] rom_fn(input logic [6:0] a);
        return 32'hC0DE_0000 | {18'd0, a, a};
    endfunction

    // Synchronous ROM: data for an address appears one cycle after it is presented.
    initial imem_dout = 32'd0;
    always @(posedge clock) imem_dout <= rom_fn(imem_addr);

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic run_row(input row_t r);
        logic [31:0] p;
        if_stall  = r.stall;
        br_taken  = r.br;
        br_target = r.tgt;
        #1;
        chk("imem_addr", 32'(imem_addr), 32'(r.addr));
        @(posedge clock);
        #1;
        p = r.pc;
        chk("if_valid", 32'(if_valid), 32'(r.valid));
        chk("if_pc", if_pc, r.pc);
        chk("halted", 32'(halted), 32'(r.halt));
        chk("fetch_count", 32'(fetch_count), 32'(r.cnt));
        if (r.valid) chk("if_instr", if_instr, rom_fn(p[8:2]));
    endtask

    task automatic check_reset_state();
        chk("rst_valid", 32'(if_valid), 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_pc", if_pc, 32'd0);
        chk("rst_addr", 32'(imem_addr), 32'd0);
        chk("rst_count", 32'(fetch_count), 32'd0);
    endtask

    task automatic do_reset();
        Reset = 1'b0;
        #1;
        check_reset_state();
        @(posedge clock);
        #1;
        check_reset_state();
        Reset = 1'b1;
    endtask

    initial begin
        // stall, br, target, addr, valid, pc, halted, count
        t1[0] = '{1'b0, 1'b0, 32'd0,    7'd0, 1'b1, 32'd0,    1'b0, 16'd0};
        t1[1] = '{1'b0, 1'b0, 32'd0,    7'd1, 1'b1, 32'd4,    1'b0, 16'd1};
        t1[2] = '{1'b0, 1'b0, 32'd0,    7'd2, 1'b1, 32'd8,    1'b0, 16'd2};
        t1[3] = '{1'b1, 1'b0, 32'd0,    7'd2, 1'b1, 32'd8,    1'b0, 16'd2};
        t1[4] = '{1'b1, 1'b0, 32'd0,    7'd2, 1'b1, 32'd8,    1'b0, 16'd2};
        t1[5] = '{1'b1, 1'b0, 32'd0,    7'd2, 1'b1, 32'd8,    1'b0, 16'd2};
        t1[6] = '{1'b0, 1'b0, 32'd0,    7'd3, 1'b1, 32'd12,   1'b0, 16'd3};
        t1[7] = '{1'b1, 1'b1, 32'h22,   7'd8, 1'b1, 32'h20,   1'b0, 16'd3};
        t1[8] = '{1'b0, 1'b0, 32'd0,    7'd9, 1'b1, 32'h24,   1'b0, 16'd4};
        t2[0] = '{1'b1, 1'b0, 32'd0,    7'd34, 1'b0, 32'd136, 1'b1, 16'd35};
        t2[1] = '{1'b0, 1'b1, 32'd200,  7'd34, 1'b0, 32'd136, 1'b1, 16'd35};
        t2[2] = '{1'b0, 1'b1, 32'd16,   7'd4,  1'b1, 32'd16,  1'b0, 16'd35};
        t2[3] = '{1'b0, 1'b0, 32'd0,    7'd5,  1'b1, 32'd20,  1'b0, 16'd36};
        t2[4] = '{1'b0, 1'b0, 32'd0,    7'd6,  1'b1, 32'd24,  1'b0, 16'd37};
        t2[5] = '{1'b0, 1'b0, 32'd0,    7'd7,  1'b1, 32'd28,  1'b0, 16'd38};
        t2[6] = '{1'b0, 1'b0, 32'd0,    7'd8,  1'b1, 32'd32,  1'b0, 16'd39};
        t2[7] = '{1'b0, 1'b0, 32'd0,    7'd9,  1'b1, 32'd36,  1'b0, 16'd40};
        t2[8] = '{1'b0, 1'b0, 32'd0,    7'd10, 1'b1, 32'd40,  1'b0, 16'd41};
        t2[9] = '{1'b0, 1'b0, 32'd0,    7'd10, 1'b1, 32'd40,  1'b0, 16'd41};

        Reset = 1'b1; if_stall = 1'b0; br_taken = 1'b0; br_target = 32'd0;
        #1;
        do_reset();

        // Start-up, 3-cycle stall at pc 8, redirect while stalled.
        for (int i = 0; i < 9; i++) run_row(t1[i]);

        // Free run from reset to the end of the program.
        do_reset();
        for (int i = 0; i < 35; i++)
            run_row('{1'b0, 1'b0, 32'd0, 7'(i), 1'b1, 32'(4 * i), 1'b0, 16'(i)});
        run_row('{1'b0, 1'b0, 32'd0, 7'd34, 1'b0, 32'd136, 1'b1, 16'd35});

        // Halt is sticky except for an in-range redirect; then run up to pc 40.
        for (int i = 0; i < 9; i++) run_row(t2[i]);

        // Asynchronous reset in the middle of a run, then restart.
        Reset = 1'b0;
        #1;
        check_reset_state();
        @(posedge clock);
        #1;
        check_reset_state();
        Reset = 1'b1;
        run_row('{1'b0, 1'b0, 32'd0, 7'd0, 1'b1, 32'd0, 1'b0, 16'd0});
        run_row('{1'b0, 1'b0, 32'd0, 7'd1, 1'b1, 32'd4, 1'b0, 16'd1});

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
